// File: rtl/axis_fft_framer.sv
// axis_fft_framer: per-frame front end for the streaming FFT core.
// Accepts a transform request, issues the FFT config word, then forwards
// exactly N = 2^L samples, zero-padding short packets and draining long ones.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a request; ctrl_ready high
// S_CFG   | config word presented until the FFT core accepts it
// S_DATA  | input passes straight through to the FFT data channel
// S_PAD   | input packet ended early; zero samples fill the frame
// S_DRAIN | frame complete; remaining input discarded up to its tlast
module axis_fft_framer #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 12,
  parameter int MIN_LOG2N = 3,
  parameter int CNT_W     = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        ctrl_log2n,
  input  logic              ctrl_fwd,
  input  logic              ctrl_valid,
  output logic              ctrl_ready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic [23:0]       m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic [DATA_W-1:0] m_axis_data_tdata,
  output logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  output logic              m_axis_data_tlast,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              evt_pad,
  output logic              evt_trunc
);

  localparam int CW = MAX_LOG2N + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_DATA,
    S_PAD,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic             r_ctrl_ready;
  logic             r_cfg_valid;
  logic [23:0]      r_cfg_data;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_last_idx;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_evt_pad;
  logic             r_evt_trunc;

  logic [3:0]       w_l;
  logic [CW-1:0]    w_n_m1;
  logic             w_in_data;
  logic             w_in_pad;
  logic             w_last;
  logic             w_m_beat;

  // Scale schedule for the pipelined FFT stages, indexed by clamped L
  function automatic logic [11:0] f_scale(input logic [3:0] l);
    logic [11:0] s;
    case (l)
      4'd4:    s = 12'd10;
      4'd5:    s = 12'd26;
      4'd6:    s = 12'd42;
      4'd7:    s = 12'd106;
      4'd8:    s = 12'd170;
      4'd9:    s = 12'd426;
      4'd10:   s = 12'd682;
      4'd11:   s = 12'd1706;
      default: s = (l <= 4'd3) ? 12'd6 : 12'd2730;
    endcase
    return s;
  endfunction

  // Clamp the requested size and derive the index of the last sample
  always_comb begin
    w_l = ctrl_log2n;
    if (int'(ctrl_log2n) < MIN_LOG2N) w_l = 4'(MIN_LOG2N);
    if (int'(ctrl_log2n) > MAX_LOG2N) w_l = 4'(MAX_LOG2N);
    w_n_m1 = (CW'(1) << w_l) - CW'(1);
  end

  assign w_in_data = (r_state == S_DATA);
  assign w_in_pad  = (r_state == S_PAD);
  assign w_last    = (r_cnt == r_last_idx);
  assign w_m_beat  = m_axis_data_tvalid & m_axis_data_tready;

  assign ctrl_ready           = r_ctrl_ready;
  assign m_axis_config_tdata  = r_cfg_data;
  assign m_axis_config_tvalid = r_cfg_valid;
  assign m_axis_data_tvalid   = (w_in_data & s_axis_tvalid) | w_in_pad;
  assign m_axis_data_tdata    = w_in_data ? s_axis_tdata : '0;
  assign m_axis_data_tlast    = (w_in_data | w_in_pad) & w_last;
  assign s_axis_tready        = (w_in_data & m_axis_data_tready) | (r_state == S_DRAIN);
  assign frame_cnt            = r_frame_cnt;
  assign evt_pad              = r_evt_pad;
  assign evt_trunc            = r_evt_trunc;

  // Frame sequencer: request, config handshake, data/pad/drain, frame count
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_IDLE;
      r_ctrl_ready <= 1'b1;
      r_cfg_valid  <= 1'b0;
      r_cfg_data   <= '0;
      r_cnt        <= '0;
      r_last_idx   <= '0;
      r_frame_cnt  <= '0;
      r_evt_pad    <= 1'b0;
      r_evt_trunc  <= 1'b0;
    end else begin
      r_evt_pad   <= 1'b0;
      r_evt_trunc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ctrl_valid) begin
            r_cfg_data   <= {3'b000, f_scale(w_l), ctrl_fwd, 4'b0000, w_l};
            r_last_idx   <= w_n_m1;
            r_cfg_valid  <= 1'b1;
            r_ctrl_ready <= 1'b0;
            r_state      <= S_CFG;
          end
        end
        S_CFG: begin
          if (m_axis_config_tready) begin
            r_cfg_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_m_beat) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              if (s_axis_tlast) begin
                r_state      <= S_IDLE;
                r_ctrl_ready <= 1'b1;
              end else begin
                r_state     <= S_DRAIN;
                r_evt_trunc <= 1'b1;
              end
            end else if (s_axis_tlast) begin
              r_state   <= S_PAD;
              r_evt_pad <= 1'b1;
            end
          end
        end
        S_PAD: begin
          if (m_axis_data_tready) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
              r_state      <= S_IDLE;
              r_ctrl_ready <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (s_axis_tvalid && s_axis_tlast) begin
            r_state      <= S_IDLE;
            r_ctrl_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_ctrl_ready <= 1'b1;
          r_cfg_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_fft_framer.sv
// Self-checking bench for axis_fft_framer: directed frames with a sample
// scoreboard, config-word checks, event/frame counters and a mid-frame reset.
module tb_axis_fft_framer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  ctrl_log2n;
  logic        ctrl_fwd;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [23:0] m_axis_config_tdata;
  logic        m_axis_config_tvalid;
  logic        m_axis_config_tready;
  logic [31:0] m_axis_data_tdata;
  logic        m_axis_data_tvalid;
  logic        m_axis_data_tready;
  logic        m_axis_data_tlast;
  logic [15:0] frame_cnt;
  logic        evt_pad;
  logic        evt_trunc;

  int n_vec = 0;
  int n_err = 0;
  int exp_fc = 0;

  logic [31:0] in_q[$];
  logic [32:0] sb[$];

  always #5 aclk = ~aclk;

  axis_fft_framer dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .ctrl_log2n           (ctrl_log2n),
    .ctrl_fwd             (ctrl_fwd),
    .ctrl_valid           (ctrl_valid),
    .ctrl_ready           (ctrl_ready),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .m_axis_config_tdata  (m_axis_config_tdata),
    .m_axis_config_tvalid (m_axis_config_tvalid),
    .m_axis_config_tready (m_axis_config_tready),
    .m_axis_data_tdata    (m_axis_data_tdata),
    .m_axis_data_tvalid   (m_axis_data_tvalid),
    .m_axis_data_tready   (m_axis_data_tready),
    .m_axis_data_tlast    (m_axis_data_tlast),
    .frame_cnt            (frame_cnt),
    .evt_pad              (evt_pad),
    .evt_trunc            (evt_trunc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ctrl_valid           = 1'b0;
    s_axis_tvalid        = 1'b0;
    s_axis_tdata         = '0;
    s_axis_tlast         = 1'b0;
    m_axis_config_tready = 1'b0;
    m_axis_data_tready   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl_ready"}, {31'd0, ctrl_ready}, 32'd1);
    chk({tag, "_cfg_tdata"},  {8'd0, m_axis_config_tdata}, 32'd0);
    chk({tag, "_cfg_tvalid"}, {31'd0, m_axis_config_tvalid}, 32'd0);
    chk({tag, "_dat_tdata"},  m_axis_data_tdata, 32'd0);
    chk({tag, "_dat_tvalid"}, {31'd0, m_axis_data_tvalid}, 32'd0);
    chk({tag, "_dat_tlast"},  {31'd0, m_axis_data_tlast}, 32'd0);
    chk({tag, "_s_tready"},   {31'd0, s_axis_tready}, 32'd0);
    chk({tag, "_frame_cnt"},  {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_evt_pad"},    {31'd0, evt_pad}, 32'd0);
    chk({tag, "_evt_trunc"},  {31'd0, evt_trunc}, 32'd0);
  endtask

  // One frame: request, config (optionally stalled), data with scoreboard.
  // abort_at >= 0 asserts reset after that many output beats.
  task automatic run_frame(input logic [3:0] lg, input logic f, input int n_in,
                           input logic [23:0] exp_cfg, input int cfg_hold,
                           input bit rnd, input int exp_pad, input int exp_trunc,
                           input int abort_at);
    int L, N, ci, co, cyc, hold, pad_cnt, trunc_cnt, bad_early, busy, cfg_seen;
    bit cfg_done, prev_stall, aborted;
    logic [32:0] prev_out, e;
    L = (lg < 3) ? 3 : ((lg > 12) ? 12 : int'(lg));
    N = 1 << L;
    in_q.delete();
    for (int k = 0; k < n_in; k++) in_q.push_back($urandom);
    for (int k = 0; k < N; k++)
      sb.push_back({k == N - 1, (k < n_in) ? in_q[k] : 32'd0});
    ctrl_log2n = lg;
    ctrl_fwd   = f;
    ctrl_valid = 1'b1;
    @(negedge aclk);
    chk("req_ready", {31'd0, ctrl_ready}, 32'd1);
    @(posedge aclk); #1;
    ctrl_valid = 1'b0;
    ci = 0; co = 0; cyc = 0; hold = cfg_hold; pad_cnt = 0; trunc_cnt = 0;
    bad_early = 0; busy = 0; cfg_seen = 0; cfg_done = 0; prev_stall = 0;
    aborted = 0; prev_out = '0;
    while (!(cfg_done && co == N && ci == n_in)) begin
      m_axis_config_tready = (!cfg_done && hold == 0);
      s_axis_tvalid = (ci < n_in);
      s_axis_tdata  = (ci < n_in) ? in_q[ci] : 32'd0;
      s_axis_tlast  = (ci == n_in - 1);
      m_axis_data_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge aclk);
      if (ctrl_ready) busy++;
      pad_cnt   += int'(evt_pad);
      trunc_cnt += int'(evt_trunc);
      if (!cfg_done) begin
        if (m_axis_data_tvalid || s_axis_tready) bad_early++;
        if (m_axis_config_tvalid) begin
          chk("cfg_word", {8'd0, m_axis_config_tdata}, {8'd0, exp_cfg});
          cfg_seen++;
          if (m_axis_config_tready) cfg_done = 1;
          if (hold > 0) hold--;
        end
      end else begin
        if (prev_stall) begin
          chk("stall_valid", {31'd0, m_axis_data_tvalid}, 32'd1);
          chk("stall_data", {m_axis_data_tlast, m_axis_data_tdata}, prev_out);
        end
        if (m_axis_data_tvalid && m_axis_data_tready) begin
          if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            chk("out_data", m_axis_data_tdata, e[31:0]);
            chk("out_tlast", {31'd0, m_axis_data_tlast}, {31'd0, e[32]});
          end
          co++;
        end
        prev_stall = m_axis_data_tvalid && !m_axis_data_tready;
        prev_out   = {m_axis_data_tlast, m_axis_data_tdata};
        if (s_axis_tvalid && s_axis_tready) ci++;
      end
      if (abort_at >= 0 && co == abort_at) begin
        #2 aresetn = 1'b0;
        #1 check_reset_outputs("abort");
        idle_inputs();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        sb.delete();
        exp_fc = 0;
        aborted = 1;
        break;
      end
      cyc++;
      if (cyc > 30000) begin
        chk("frame_timeout", 32'd1, 32'd0);
        break;
      end
      @(posedge aclk); #1;
    end
    idle_inputs();
    if (!aborted) exp_fc = (exp_fc + 1) & 16'hFFFF;
    @(negedge aclk);
    chk("frame_cnt", {16'd0, frame_cnt}, exp_fc);
    chk("idle_ready", {31'd0, ctrl_ready}, 32'd1);
    chk("idle_cfg_valid", {31'd0, m_axis_config_tvalid}, 32'd0);
    if (!aborted) begin
      chk("cfg_seen", (cfg_seen > 0) ? 32'd1 : 32'd0, 32'd1);
      chk("no_early_data", bad_early, 32'd0);
      chk("ready_while_busy", busy, 32'd0);
      chk("evt_pad_cnt", pad_cnt, exp_pad);
      chk("evt_trunc_cnt", trunc_cnt, exp_trunc);
      chk("beats_out", co, N);
      chk("sb_empty", sb.size(), 32'd0);
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    aresetn = 1'b0;
    ctrl_log2n = '0;
    ctrl_fwd = 1'b0;
    idle_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_reset_outputs("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    run_frame(4'd9,  1'b1, 512,  24'h035509, 0, 0, 0, 0, -1);
    run_frame(4'd9,  1'b0, 512,  24'h035409, 0, 0, 0, 0, -1);
    run_frame(4'd4,  1'b0, 10,   24'h001404, 0, 0, 1, 0, -1);
    run_frame(4'd3,  1'b1, 12,   24'h000D03, 0, 0, 0, 1, -1);
    run_frame(4'd15, 1'b0, 4096, 24'h15540C, 5, 1, 0, 0, -1);
    run_frame(4'd3,  1'b0, 1,    24'h000C03, 0, 1, 1, 0, -1);
    run_frame(4'd1,  1'b0, 8,    24'h000C03, 2, 0, 0, 0, -1);
    run_frame(4'd9,  1'b1, 512,  24'h035509, 0, 0, 0, 0, 100);
    run_frame(4'd4,  1'b0, 16,   24'h001404, 0, 1, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
